// File: rtl/prog_counter_fsm.sv
// prog_counter_fsm: run-controlled programmable up/down counter with terminal limit, wrap/saturate and sticky flags
// Ports: clk, reset (sync, active-high); start/stop run control; load/load_value parallel load;
//   mode (00 +1, 01 -1, 10 +step, 11 -step), step operand; limit_we/limit_in terminal limit write;
//   saturate (0 wrap, 1 clamp); one_shot (park in DONE after first event); clear_flags;
//   count, running, tc (registered event pulse), ovf_sticky, unf_sticky.
// Optional: define PROG_COUNTER_PRESCALE_EN to add parameter PRESC_W and input prescale,
//   giving one tick every prescale+1 RUN cycles.
module prog_counter_fsm #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_LIMIT = {WIDTH{1'b1}}
`ifdef PROG_COUNTER_PRESCALE_EN
  , parameter int PRESC_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  input  logic             limit_we,
  input  logic [WIDTH-1:0] limit_in,
  input  logic             saturate,
  input  logic             one_shot,
  input  logic             clear_flags,
`ifdef PROG_COUNTER_PRESCALE_EN
  input  logic [PRESC_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             tc,
  output logic             ovf_sticky,
  output logic             unf_sticky
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, limit_q, operand, tick_val;
  logic [WIDTH:0] sum;
  logic running_q, tc_q, ovf_q, unf_q;
  logic tick, up_ev, dn_ev, ev, psc_zero;
`ifdef PROG_COUNTER_PRESCALE_EN
  logic [PRESC_W-1:0] psc_q;
  assign psc_zero = psc_q == '0;
`else
  assign psc_zero = 1'b1;
`endif
  always_comb begin
    operand  = mode[1] ? step : {{(WIDTH-1){1'b0}}, 1'b1};
    sum      = {1'b0, count_q} + {1'b0, operand};
    // a zero operand never moves the count, so it can never be an event
    up_ev    = (|operand) && (sum > {1'b0, limit_q});
    dn_ev    = operand > count_q;
    ev       = mode[0] ? dn_ev : up_ev;
    tick     = (state_q == RUN) && !load && !stop && psc_zero;
    tick_val = mode[0] ? (dn_ev ? (saturate ? '0 : limit_q) : count_q - operand)
                       : (up_ev ? (saturate ? limit_q : '0) : sum[WIDTH-1:0]);
    count_d  = load ? load_value : tick ? tick_val : count_q;
    // load blocks start but a simultaneous stop still returns RUN to IDLE
    state_d  = ((load && state_q == DONE) || (stop && state_q == RUN)) ? IDLE :
               (start && !load && state_q != RUN) ? RUN :
               (tick && ev && one_shot) ? DONE : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      limit_q   <= RESET_LIMIT;
      running_q <= 1'b0;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      limit_q   <= limit_we ? limit_in : limit_q;
      running_q <= state_d == RUN;
      tc_q      <= tick && ev;
      ovf_q     <= (tick && ev && !mode[0]) || (ovf_q && !clear_flags);
      unf_q     <= (tick && ev && mode[0]) || (unf_q && !clear_flags);
    end
  end
`ifdef PROG_COUNTER_PRESCALE_EN
  always_ff @(posedge clk) begin
    if (reset || load || stop || (start && state_q != RUN))
      psc_q <= prescale;
    else if (state_q == RUN)
      psc_q <= psc_zero ? prescale : psc_q - {{(PRESC_W-1){1'b0}}, 1'b1};
  end
`endif
  assign count      = count_q;
  assign running    = running_q;
  assign tc         = tc_q;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;
endmodule

// File: tb/tb_prog_counter_fsm.sv
// tb_prog_counter_fsm: directed and randomized checks of prog_counter_fsm against a behavioural model
module tb_prog_counter_fsm;
  localparam int W = 8;
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;
  logic clk = 0, reset = 0, start = 0, stop = 0, load = 0, limit_we = 0;
  logic saturate = 0, one_shot = 0, clear_flags = 0;
  logic [W-1:0] load_value = 0, step = 0, limit_in = 0;
  logic [1:0] mode = 0;
`ifdef PROG_COUNTER_PRESCALE_EN
  logic [7:0] prescale = 0;
  int m_psc;
`endif
  logic [W-1:0] count;
  logic running, tc, ovf_sticky, unf_sticky;
  int pass_cnt = 0, total_cnt = 0;
  int m_count, m_limit, m_st;
  bit m_tc, m_ovf, m_unf;

  always #5 clk = ~clk;

  prog_counter_fsm #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
    .load_value(load_value), .mode(mode), .step(step), .limit_we(limit_we),
    .limit_in(limit_in), .saturate(saturate), .one_shot(one_shot),
    .clear_flags(clear_flags),
`ifdef PROG_COUNTER_PRESCALE_EN
    .prescale(prescale),
`endif
    .count(count), .running(running), .tc(tc),
    .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
  );

  task automatic model();
    int op, nc;
    bit tk, ev, up;
    if (reset) begin
      m_count = 0; m_limit = 255; m_st = S_IDLE; m_tc = 0; m_ovf = 0; m_unf = 0;
`ifdef PROG_COUNTER_PRESCALE_EN
      m_psc = prescale;
`endif
    end else begin
      op = mode[1] ? int'(step) : 1;
      up = !mode[0];
      tk = (m_st == S_RUN) && !load && !stop;
`ifdef PROG_COUNTER_PRESCALE_EN
      tk = tk && (m_psc == 0);
      if (load || stop || (start && m_st != S_RUN)) m_psc = prescale;
      else if (m_st == S_RUN) m_psc = (m_psc == 0) ? int'(prescale) : m_psc - 1;
`endif
      ev = 0;
      if (up) begin
        if (op > 0 && m_count + op > m_limit) begin ev = 1; nc = saturate ? m_limit : 0; end
        else nc = m_count + op;
      end else begin
        if (op > m_count) begin ev = 1; nc = saturate ? 0 : m_limit; end
        else nc = m_count - op;
      end
      if ((load && m_st == S_DONE) || (stop && m_st == S_RUN)) m_st = S_IDLE;
      else if (start && !load && m_st != S_RUN) m_st = S_RUN;
      else if (tk && ev && one_shot) m_st = S_DONE;
      if (load) m_count = load_value;
      else if (tk) m_count = nc;
      m_tc  = tk && ev;
      m_ovf = (tk && ev && up) || (m_ovf && !clear_flags);
      m_unf = (tk && ev && !up) || (m_unf && !clear_flags);
      if (limit_we) m_limit = limit_in;
    end
  endtask

  task automatic clk_tick();
    model();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; clk_tick(); reset = 0;
    total_cnt++; if (count !== 8'd0) $display("FAIL reset_count got=%0d exp=0", count); else pass_cnt++;
    total_cnt++; if (running !== 1'b0) $display("FAIL reset_running got=%0b exp=0", running); else pass_cnt++;
    total_cnt++; if (tc !== 1'b0) $display("FAIL reset_tc got=%0b exp=0", tc); else pass_cnt++;
    total_cnt++; if ({ovf_sticky, unf_sticky} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {ovf_sticky, unf_sticky}); else pass_cnt++;
  endtask

  task automatic test_wrap_up();
    int ec;
    limit_we = 1; limit_in = 10; mode = 0; saturate = 0; one_shot = 0; clk_tick(); limit_we = 0;
    start = 1; clk_tick(); start = 0;
    total_cnt++; if (running !== 1'b1 || count !== 8'd0) $display("FAIL wrap_start got run=%0b cnt=%0d exp run=1 cnt=0", running, count); else pass_cnt++;
    for (int i = 1; i <= 12; i++) begin
      clk_tick();
      ec = (i <= 10) ? i : i - 11;
      total_cnt++; if (count !== ec[7:0]) $display("FAIL wrap_count[%0d] got=%0d exp=%0d", i, count, ec); else pass_cnt++;
      total_cnt++; if (tc !== (i == 11)) $display("FAIL wrap_tc[%0d] got=%0b exp=%0b", i, tc, i == 11); else pass_cnt++;
    end
    total_cnt++; if (ovf_sticky !== 1'b1 || unf_sticky !== 1'b0) $display("FAIL wrap_flags got=%b exp=10", {ovf_sticky, unf_sticky}); else pass_cnt++;
  endtask

  task automatic test_sat_down();
    stop = 1; clk_tick(); stop = 0;
    load = 1; load_value = 3; mode = 3; step = 5; saturate = 1; clk_tick(); load = 0;
    start = 1; clk_tick(); start = 0;
    total_cnt++; if (count !== 8'd3 || running !== 1'b1) $display("FAIL sat_start got cnt=%0d run=%0b exp cnt=3 run=1", count, running); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      clk_tick();
      total_cnt++; if (count !== 8'd0 || tc !== 1'b1 || unf_sticky !== 1'b1) $display("FAIL sat_tick[%0d] got cnt=%0d tc=%0b unf=%0b exp 0 1 1", i, count, tc, unf_sticky); else pass_cnt++;
    end
  endtask

  task automatic test_one_shot();
    stop = 1; limit_we = 1; limit_in = 4; clk_tick(); stop = 0; limit_we = 0;
    load = 1; load_value = 2; mode = 2; step = 2; saturate = 0; one_shot = 1; clk_tick(); load = 0;
    start = 1; clk_tick(); start = 0;
    clk_tick();
    total_cnt++; if (count !== 8'd4 || tc !== 1'b0 || running !== 1'b1) $display("FAIL oneshot_t1 got cnt=%0d tc=%0b run=%0b exp 4 0 1", count, tc, running); else pass_cnt++;
    clk_tick();
    total_cnt++; if (count !== 8'd0 || tc !== 1'b1 || running !== 1'b0) $display("FAIL oneshot_ev got cnt=%0d tc=%0b run=%0b exp 0 1 0", count, tc, running); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      clk_tick();
      total_cnt++; if (count !== 8'd0 || tc !== 1'b0 || running !== 1'b0) $display("FAIL oneshot_done[%0d] got cnt=%0d tc=%0b run=%0b exp 0 0 0", i, count, tc, running); else pass_cnt++;
    end
    start = 1; one_shot = 0; clk_tick(); start = 0;
    total_cnt++; if (running !== 1'b1 || count !== 8'd0) $display("FAIL oneshot_restart got run=%0b cnt=%0d exp 1 0", running, count); else pass_cnt++;
  endtask

  task automatic test_priority();
    start = 1; stop = 1; load = 1; load_value = 7; limit_we = 1; limit_in = 20; clk_tick();
    stop = 0; load = 0; limit_we = 0;
    total_cnt++; if (count !== 8'd7 || running !== 1'b0) $display("FAIL prio_all got cnt=%0d run=%0b exp 7 0", count, running); else pass_cnt++;
    mode = 0; clk_tick(); start = 0;
    clk_tick();
    total_cnt++; if (count !== 8'd8 || running !== 1'b1) $display("FAIL prio_tick got cnt=%0d run=%0b exp 8 1", count, running); else pass_cnt++;
    stop = 1; clk_tick(); stop = 0;
    total_cnt++; if (count !== 8'd8 || running !== 1'b0) $display("FAIL prio_stop got cnt=%0d run=%0b exp 8 0", count, running); else pass_cnt++;
    clk_tick();
    total_cnt++; if (count !== 8'd8) $display("FAIL prio_hold got cnt=%0d exp 8", count); else pass_cnt++;
  endtask

  task automatic test_sticky();
    clear_flags = 1; clk_tick(); clear_flags = 0;
    total_cnt++; if ({ovf_sticky, unf_sticky} !== 2'b00) $display("FAIL sticky_clear got=%b exp=00", {ovf_sticky, unf_sticky}); else pass_cnt++;
    limit_we = 1; limit_in = 4; load = 1; load_value = 4; mode = 0; saturate = 0; clk_tick();
    limit_we = 0; load = 0;
    start = 1; clk_tick(); start = 0;
    clear_flags = 1; clk_tick();
    total_cnt++; if (ovf_sticky !== 1'b1 || tc !== 1'b1 || count !== 8'd0) $display("FAIL sticky_setwins got ovf=%0b tc=%0b cnt=%0d exp 1 1 0", ovf_sticky, tc, count); else pass_cnt++;
    stop = 1; clk_tick(); clear_flags = 0; stop = 0;
    total_cnt++; if (ovf_sticky !== 1'b0) $display("FAIL sticky_cleared got=%0b exp=0", ovf_sticky); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    limit_we = 1; limit_in = 10; load = 1; load_value = 0; mode = 0; clk_tick();
    limit_we = 0; load = 0;
    start = 1; clk_tick(); start = 0;
    repeat (5) clk_tick();
    total_cnt++; if (count !== 8'd5) $display("FAIL midrun_count got=%0d exp=5", count); else pass_cnt++;
    reset = 1; clk_tick(); reset = 0;
    total_cnt++; if (count !== 8'd0 || running !== 1'b0 || tc !== 1'b0) $display("FAIL midrun_reset got cnt=%0d run=%0b tc=%0b exp 0 0 0", count, running, tc); else pass_cnt++;
  endtask

`ifdef PROG_COUNTER_PRESCALE_EN
  task automatic test_prescale();
    prescale = 3; mode = 0; limit_we = 1; limit_in = 200; load = 1; load_value = 0; clk_tick();
    limit_we = 0; load = 0;
    start = 1; clk_tick(); start = 0;
    for (int i = 1; i <= 8; i++) begin
      clk_tick();
      total_cnt++; if (count !== 8'(i / 4)) $display("FAIL presc_count[%0d] got=%0d exp=%0d", i, count, i / 4); else pass_cnt++;
    end
    clk_tick(); clk_tick();
    stop = 1; clk_tick(); stop = 0;
    start = 1; clk_tick(); start = 0;
    for (int i = 1; i <= 4; i++) begin
      clk_tick();
      total_cnt++; if (count !== 8'(2 + i / 4)) $display("FAIL presc_restart[%0d] got=%0d exp=%0d", i, count, 2 + i / 4); else pass_cnt++;
    end
    prescale = 0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 59) == 0);
      start       = ($urandom_range(0, 3) == 0);
      stop        = ($urandom_range(0, 11) == 0);
      load        = ($urandom_range(0, 13) == 0);
      load_value  = 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 30));
      limit_we    = ($urandom_range(0, 11) == 0);
      limit_in    = 8'($urandom_range(0, 4) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 25));
      mode        = 2'($urandom_range(0, 3));
      step        = 8'($urandom_range(0, 5) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 6));
      saturate    = 1'($urandom_range(0, 1));
      one_shot    = ($urandom_range(0, 3) == 0);
      clear_flags = ($urandom_range(0, 7) == 0);
`ifdef PROG_COUNTER_PRESCALE_EN
      prescale    = 8'($urandom_range(0, 2));
`endif
      clk_tick();
      total_cnt++; if (count !== m_count[7:0]) $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, count, m_count); else pass_cnt++;
      total_cnt++; if (running !== (m_st == S_RUN)) $display("FAIL rand_running[%0d] got=%0b exp=%0b", i, running, m_st == S_RUN); else pass_cnt++;
      total_cnt++; if (tc !== m_tc) $display("FAIL rand_tc[%0d] got=%0b exp=%0b", i, tc, m_tc); else pass_cnt++;
      total_cnt++; if (ovf_sticky !== m_ovf) $display("FAIL rand_ovf[%0d] got=%0b exp=%0b", i, ovf_sticky, m_ovf); else pass_cnt++;
      total_cnt++; if (unf_sticky !== m_unf) $display("FAIL rand_unf[%0d] got=%0b exp=%0b", i, unf_sticky, m_unf); else pass_cnt++;
    end
    reset = 0; start = 0; stop = 0; load = 0; limit_we = 0; clear_flags = 0;
  endtask

  initial begin
    #2;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_one_shot();
    test_priority();
    test_sticky();
    test_reset_mid_run();
`ifdef PROG_COUNTER_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
